btb_predictor: RTL and testbench
================================

// Module: btb_predictor
// PURPOSE
//  Parametrised branch target buffer with 2-bit saturating direction counters; successor to the fixed single-entry BTB.
//  Sits beside the PC register: predicts the next fetch PC in the same cycle from the current PC.
//  Is trained by the EXE stage, and flags mispredictions so hazard logic can flush IF/ID.
// PARAMETERS
//  PC_W     16  PC / target width in bits
//  ENTRIES  16  number of direct-mapped entries; power of two, >=2; IDX_W = $clog2(ENTRIES)
//  STAT_W   16  width of statistics counters (BTB_STATS_EN only)
// PORTS
//  clk            in   1      clock; all state updates on rising edge
//  rst            in   1      asynchronous, active-low reset
//  flush          in   1      synchronous invalidate of all entries
//  cur_pc         in   PC_W   fetch PC being looked up
//  pred_taken     out  1      lookup hit and counter MSB = 1
//  pred_pc        out  PC_W   stored target if pred_taken, else cur_pc+1
//  upd_valid      in   1      EXE holds a resolved branch/jump this cycle
//  upd_pc         in   PC_W   PC of the resolved instruction
//  upd_taken      in   1      actual outcome
//  upd_target     in   PC_W   actual target when taken
//  upd_pred_taken in   1      prediction carried down the pipe with this instruction
//  upd_pred_pc    in   PC_W   predicted next PC carried with this instruction
//  mispredict     out  1      prediction wrong; hazard unit clears IF/ID and ID/EXE
//  redirect_pc    out  PC_W   correct next PC: upd_taken ? upd_target : upd_pc+1
//  hit_cnt        out  STAT_W lookups that predicted taken (BTB_STATS_EN only)
//  miss_cnt       out  STAT_W mispredicts (BTB_STATS_EN only)
// BEHAVIOUR
//  Entry: valid, tag = pc[PC_W-1:IDX_W], target, ctr[1:0]; index = pc[IDX_W-1:0].
//  Lookup: combinational, zero latency. Hit = valid && tag match.
//  Lookup returns pre-edge contents: an update to the same index takes effect for fetches from the next cycle on.
//  Mispredict: combinational from upd_* inputs: upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_pc)).
//  Mispredict is 0 when upd_valid = 0.
//  Update on a hit to the upd_pc entry: ctr +1 if taken, -1 if not; saturates at 3 / 0.
//  Target is rewritten when taken.
//  Update on a miss, taken: allocate by overwriting the indexed entry; valid = 1, tag, target, ctr = 2'b10 (weakly taken).
//  Update on a miss, not taken: no allocation, no state change.
//  Flush: clears all valid bits next edge; flush wins over a simultaneous update.
//  Reset: all valid = 0, ctr = 2'b01, target = 0; outputs pred_taken = 0, pred_pc = cur_pc+1, mispredict = 0, stats = 0.
//  Reset asserted mid-update: update discarded; state is reset immediately (asynchronous).
//  Arithmetic: +1 wraps modulo 2^PC_W (PC 16'hFFFF -> 16'h0000).
// CONFIGURATION
//  BTB_STATS_EN defined: hit_cnt increments each cycle pred_taken = 1.
//  BTB_STATS_EN defined: miss_cnt increments each cycle mispredict = 1.
//  Both counters saturate at all-ones, clear on reset and on flush.
//  BTB_STATS_EN undefined: hit_cnt / miss_cnt tied to 0; no counter flops generated.
// STRUCTURE
//  Package btb_pkg: ctr encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11; CTR_ALLOC = WT; CTR_RESET = WNT.
//  btb_pkg also holds the btb_entry_t struct typedef.
//  Sub-module sat_ctr2: pure function next = f(ctr, taken); instantiated once on the update path.
//  Entry storage is a flop array (async reset needed; no RAM inference).
// TESTING
//  After reset, cur_pc = 16'h0010 -> pred_taken = 0, pred_pc = 16'h0011.
//  Allocate: update pc = 16'h0010, taken, target 16'h0040, pred_taken = 0 -> mispredict = 1, redirect = 16'h0040.
//    Next cycle, lookup 16'h0010 -> pred_taken = 1, pred_pc = 16'h0040.
//  Saturation: after 3 taken updates then 2 not-taken at pc 16'h0010 -> ctr = WNT, pred_taken = 0.
//    A third not-taken gives SNT; a fourth stays SNT.
//  Aliasing (ENTRIES=16): allocate 16'h0010 then taken 16'h0020 (same index) -> 16'h0010 lookup misses.
//    16'h0020 lookup hits.
//  Same-cycle: lookup and allocate index 0 together -> old (miss) result this cycle, hit next.
//    Flush + update together -> entry invalid afterwards.
//  Stats (BTB_STATS_EN, STAT_W=2): 5 mispredicts -> miss_cnt = 3 (saturated); flush -> 0.
//  Async reset pulse mid-cycle clears pred_taken without waiting for clk.

Source files
------------

// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - counter encodings and entry metadata shared by the BTB predictor and its counter.
package btb_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_ALLOC = WT;
    localparam ctr_e CTR_RESET = WNT;

    // Tag and target widths follow PC_W, so they are held in sibling arrays in the top.
    typedef struct packed {
        logic valid;
        ctr_e ctr;
    } btb_entry_t;

endpackage

// File: rtl/sat_ctr2.sv
// rtl/sat_ctr2.sv - 2-bit saturating direction counter next-state function.
module sat_ctr2
    import btb_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] next
);

    always_comb begin
        next = ctr;
        if (taken) begin
            if (ctr != ST) next = ctr + 2'd1;
        end else begin
            if (ctr != SNT) next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// rtl/btb_predictor.sv - direct-mapped BTB with 2-bit counters and mispredict detection.
// Optional macro BTB_STATS_EN adds saturating hit/mispredict counters.
module btb_predictor
    import btb_pkg::*;
#(
    parameter int PC_W    = 16,
    parameter int ENTRIES = 16,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [PC_W-1:0]   cur_pc,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_pc,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic [PC_W-1:0]   upd_target,
    input  logic              upd_pred_taken,
    input  logic [PC_W-1:0]   upd_pred_pc,
    output logic              mispredict,
    output logic [PC_W-1:0]   redirect_pc,
    output logic [STAT_W-1:0] hit_cnt,
    output logic [STAT_W-1:0] miss_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W;
    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    btb_entry_t      meta  [ENTRIES];
    logic [TAG_W-1:0] tag_q [ENTRIES];
    logic [PC_W-1:0]  tgt_q [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] up_idx;
    logic             lk_hit;
    logic             up_hit;
    logic [1:0]       ctr_next;

    assign lk_idx = cur_pc[IDX_W-1:0];
    assign up_idx = upd_pc[IDX_W-1:0];
    assign lk_hit = meta[lk_idx].valid && (tag_q[lk_idx] == cur_pc[PC_W-1:IDX_W]);
    assign up_hit = meta[up_idx].valid && (tag_q[up_idx] == upd_pc[PC_W-1:IDX_W]);

    // Lookup sees pre-edge storage, so a same-index update only shows up next cycle.
    always_comb begin
        pred_taken = lk_hit && meta[lk_idx].ctr[1];
        pred_pc    = pred_taken ? tgt_q[lk_idx] : cur_pc + PC_ONE;
    end

    always_comb begin
        mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                                    (upd_taken && (upd_target != upd_pred_pc)));
        redirect_pc = upd_taken ? upd_target : upd_pc + PC_ONE;
    end

    sat_ctr2 u_ctr (
        .ctr   (meta[up_idx].ctr),
        .taken (upd_taken),
        .next  (ctr_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                meta[i]  <= '{valid: 1'b0, ctr: CTR_RESET};
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) meta[i].valid <= 1'b0;
        end else if (upd_valid) begin
            if (up_hit) begin
                meta[up_idx].ctr <= ctr_e'(ctr_next);
                if (upd_taken) tgt_q[up_idx] <= upd_target;
            end else if (upd_taken) begin
                meta[up_idx]  <= '{valid: 1'b1, ctr: CTR_ALLOC};
                tag_q[up_idx] <= upd_pc[PC_W-1:IDX_W];
                tgt_q[up_idx] <= upd_target;
            end
        end
    end

`ifdef BTB_STATS_EN
    logic [STAT_W-1:0] hit_q;
    logic [STAT_W-1:0] miss_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (flush) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (pred_taken && (hit_q != '1)) hit_q <= hit_q + STAT_W'(1);
            if (mispredict && (miss_q != '1)) miss_q <= miss_q + STAT_W'(1);
        end
    end

    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// tb/tb_btb_predictor.sv - scoreboard bench for btb_predictor (honours BTB_STATS_EN).
module tb_btb_predictor;

    localparam int PC_W    = 16;
    localparam int ENTRIES = 16;
`ifdef BTB_STATS_EN
    localparam int STAT_W  = 2;
`else
    localparam int STAT_W  = 16;
`endif

    logic              clk;
    logic              rst;
    logic              flush;
    logic [PC_W-1:0]   cur_pc;
    logic              pred_taken;
    logic [PC_W-1:0]   pred_pc;
    logic              upd_valid;
    logic [PC_W-1:0]   upd_pc;
    logic              upd_taken;
    logic [PC_W-1:0]   upd_target;
    logic              upd_pred_taken;
    logic [PC_W-1:0]   upd_pred_pc;
    logic              mispredict;
    logic [PC_W-1:0]   redirect_pc;
    logic [STAT_W-1:0] hit_cnt;
    logic [STAT_W-1:0] miss_cnt;

    typedef struct {
        string           name;
        logic            pt;
        logic [PC_W-1:0] ppc;
    } lk_exp_t;

    typedef struct {
        string           name;
        logic            mp;
        logic [PC_W-1:0] rpc;
    } up_exp_t;

    lk_exp_t lk_q[$];
    up_exp_t up_q[$];
    lk_exp_t le;
    up_exp_t ue;
    int errors = 0;
    int checks = 0;

    btb_predictor #(.PC_W(PC_W), .ENTRIES(ENTRIES), .STAT_W(STAT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .cur_pc         (cur_pc),
        .pred_taken     (pred_taken),
        .pred_pc        (pred_pc),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_pred_taken (upd_pred_taken),
        .upd_pred_pc    (upd_pred_pc),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc),
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [PC_W-1:0] pc, input logic uv, input logic [PC_W-1:0] upc,
                         input logic ut, input logic [PC_W-1:0] utgt, input logic upt,
                         input logic [PC_W-1:0] uppc);
        cur_pc         = pc;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_taken      = ut;
        upd_target     = utgt;
        upd_pred_taken = upt;
        upd_pred_pc    = uppc;
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int sat(input int n);
        int mx = (1 << STAT_W) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic test_reset;
        rst   = 1'b0;
        flush = 1'b0;
        drive(16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        lk_q.push_back('{name: "reset_lookup", pt: 1'b0, ppc: 16'h0011});
        up_q.push_back('{name: "reset_mispredict", mp: 1'b0, rpc: 16'h0001});
        #1;
        while (lk_q.size() > 0) begin
            le = lk_q.pop_front(); checks++;
            if (pred_taken !== le.pt || pred_pc !== le.ppc) begin
                errors++;
                $display("FAIL %s: pred_taken=%0b pred_pc=%h required %0b %h", le.name, pred_taken, pred_pc, le.pt, le.ppc);
            end
        end
        while (up_q.size() > 0) begin
            ue = up_q.pop_front(); checks++;
            if (mispredict !== ue.mp || redirect_pc !== ue.rpc) begin
                errors++;
                $display("FAIL %s: mispredict=%0b redirect_pc=%h required %0b %h", ue.name, mispredict, redirect_pc, ue.mp, ue.rpc);
            end
        end
        checks++;
        if (hit_cnt !== '0 || miss_cnt !== '0) begin
            errors++;
            $display("FAIL reset_stats: hit_cnt=%0d miss_cnt=%0d required 0 0", hit_cnt, miss_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_allocate;
        drive(16'h0010, 1'b1, 16'h0010, 1'b1, 16'h0040, 1'b0, 16'h0011);
        lk_q.push_back('{name: "alloc_same_cycle", pt: 1'b0, ppc: 16'h0011});
        up_q.push_back('{name: "alloc_mispredict", mp: 1'b1, rpc: 16'h0040});
        #1;
        while (up_q.size() > 0) begin
            ue = up_q.pop_front(); checks++;
            if (mispredict !== ue.mp || redirect_pc !== ue.rpc) begin
                errors++;
                $display("FAIL %s: mispredict=%0b redirect_pc=%h required %0b %h", ue.name, mispredict, redirect_pc, ue.mp, ue.rpc);
            end
        end
        tick;
        drive(16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        lk_q.push_back('{name: "alloc_next_cycle", pt: 1'b1, ppc: 16'h0040});
        #1;
        while (lk_q.size() > 0) begin
            le = lk_q.pop_front();
            if (le.name == "alloc_same_cycle") continue;
            checks++;
            if (pred_taken !== le.pt || pred_pc !== le.ppc) begin
                errors++;
                $display("FAIL %s: pred_taken=%0b pred_pc=%h required %0b %h", le.name, pred_taken, pred_pc, le.pt, le.ppc);
            end
        end
        tick;
    endtask

    // Entry at 0x0010 starts weakly taken; prediction after each outcome in order.
    task automatic test_saturation;
        logic outc   [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic pt_aft [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic prev = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(16'h0010, 1'b1, 16'h0010, outc[i], 16'h0040, outc[i], outc[i] ? 16'h0040 : 16'h0011);
            lk_q.push_back('{name: $sformatf("sat_lookup_%0d", i), pt: prev, ppc: prev ? 16'h0040 : 16'h0011});
            up_q.push_back('{name: $sformatf("sat_update_%0d", i), mp: 1'b0, rpc: outc[i] ? 16'h0040 : 16'h0011});
            #1;
            le = lk_q.pop_front(); checks++;
            if (pred_taken !== le.pt || pred_pc !== le.ppc) begin
                errors++;
                $display("FAIL %s: pred_taken=%0b pred_pc=%h required %0b %h", le.name, pred_taken, pred_pc, le.pt, le.ppc);
            end
            ue = up_q.pop_front(); checks++;
            if (mispredict !== ue.mp || redirect_pc !== ue.rpc) begin
                errors++;
                $display("FAIL %s: mispredict=%0b redirect_pc=%h required %0b %h", ue.name, mispredict, redirect_pc, ue.mp, ue.rpc);
            end
            prev = pt_aft[i];
            tick;
        end
        drive(16'h0010, 1'b1, 16'h0010, 1'b1, 16'h0050, 1'b1, 16'h0040);
        up_q.push_back('{name: "retarget_mispredict", mp: 1'b1, rpc: 16'h0050});
        #1;
        ue = up_q.pop_front(); checks++;
        if (mispredict !== ue.mp || redirect_pc !== ue.rpc) begin
            errors++;
            $display("FAIL %s: mispredict=%0b redirect_pc=%h required %0b %h", ue.name, mispredict, redirect_pc, ue.mp, ue.rpc);
        end
        tick;
        drive(16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        lk_q.push_back('{name: "retarget_lookup", pt: 1'b1, ppc: 16'h0050});
        #1;
        le = lk_q.pop_front(); checks++;
        if (pred_taken !== le.pt || pred_pc !== le.ppc) begin
            errors++;
            $display("FAIL %s: pred_taken=%0b pred_pc=%h required %0b %h", le.name, pred_taken, pred_pc, le.pt, le.ppc);
        end
        tick;
    endtask

    task automatic test_aliasing;
        logic [PC_W-1:0] lk_pc [4] = '{16'h0010, 16'h0020, 16'h0020, 16'h0030};
        logic            lk_pt [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [PC_W-1:0] lk_pp [4] = '{16'h0011, 16'h0070, 16'h0070, 16'h0031};
        drive(16'h0000, 1'b1, 16'h0020, 1'b1, 16'h0070, 1'b0, 16'h0021);
        tick;
        for (int i = 0; i < 4; i++) begin
            // Cycle 2 also trains a not-taken miss at the aliasing pc 0x0030.
            drive(lk_pc[i], i == 2, 16'h0030, 1'b0, 16'h0000, 1'b0, 16'h0031);
            lk_q.push_back('{name: $sformatf("alias_lookup_%0d", i), pt: lk_pt[i], ppc: lk_pp[i]});
            #1;
            le = lk_q.pop_front(); checks++;
            if (pred_taken !== le.pt || pred_pc !== le.ppc) begin
                errors++;
                $display("FAIL %s: pred_taken=%0b pred_pc=%h required %0b %h", le.name, pred_taken, pred_pc, le.pt, le.ppc);
            end
            tick;
        end
    endtask

    task automatic test_same_cycle;
        drive(16'h0105, 1'b1, 16'h0105, 1'b1, 16'h0200, 1'b0, 16'h0106);
        lk_q.push_back('{name: "same_cycle_old", pt: 1'b0, ppc: 16'h0106});
        tick;
        drive(16'h0105, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        lk_q.push_back('{name: "same_cycle_new", pt: 1'b1, ppc: 16'h0200});
        tick;
        flush = 1'b1;
        drive(16'h0105, 1'b1, 16'h0207, 1'b1, 16'h0300, 1'b0, 16'h0208);
        tick;
        flush = 1'b0;
        lk_q.push_back('{name: "flush_vs_update", pt: 1'b0, ppc: 16'h0208});
        lk_q.push_back('{name: "flush_cleared", pt: 1'b0, ppc: 16'h0106});
        lk_q.push_back('{name: "flush_other", pt: 1'b0, ppc: 16'h0021});
        // Replay the lookups in push order; the first two were taken in the earlier cycles.
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin
                    drive(16'h0105, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
                    lk_q.pop_front();
                    lk_q.pop_front();
                    continue;
                end
                1: continue;
                2: drive(16'h0207, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
                3: drive(16'h0105, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
                default: drive(16'h0020, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
            endcase
            #1;
            le = lk_q.pop_front(); checks++;
            if (pred_taken !== le.pt || pred_pc !== le.ppc) begin
                errors++;
                $display("FAIL %s: pred_taken=%0b pred_pc=%h required %0b %h", le.name, pred_taken, pred_pc, le.pt, le.ppc);
            end
            tick;
        end
    endtask

    task automatic test_same_cycle_direct;
        drive(16'h0306, 1'b1, 16'h0306, 1'b1, 16'h0400, 1'b0, 16'h0307);
        lk_q.push_back('{name: "same_cycle_pre_edge", pt: 1'b0, ppc: 16'h0307});
        #1;
        le = lk_q.pop_front(); checks++;
        if (pred_taken !== le.pt || pred_pc !== le.ppc) begin
            errors++;
            $display("FAIL %s: pred_taken=%0b pred_pc=%h required %0b %h", le.name, pred_taken, pred_pc, le.pt, le.ppc);
        end
        tick;
        drive(16'h0306, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        lk_q.push_back('{name: "same_cycle_post_edge", pt: 1'b1, ppc: 16'h0400});
        #1;
        le = lk_q.pop_front(); checks++;
        if (pred_taken !== le.pt || pred_pc !== le.ppc) begin
            errors++;
            $display("FAIL %s: pred_taken=%0b pred_pc=%h required %0b %h", le.name, pred_taken, pred_pc, le.pt, le.ppc);
        end
        tick;
    endtask

    task automatic test_mispredict;
        logic            uv   [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [PC_W-1:0] upc  [5] = '{16'h1000, 16'hFFFF, 16'h0300, 16'h0300, 16'h0300};
        logic            ut   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [PC_W-1:0] tgt  [5] = '{16'h2000, 16'h0000, 16'h1235, 16'h0000, 16'h1235};
        logic            upt  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [PC_W-1:0] uppc [5] = '{16'h0000, 16'h0000, 16'h1234, 16'h1235, 16'h1235};
        logic            mp   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [PC_W-1:0] rpc  [5] = '{16'h2000, 16'h0000, 16'h1235, 16'h0301, 16'h1235};
        for (int i = 0; i < 5; i++) begin
            drive(16'hFFFF, uv[i], upc[i], ut[i], tgt[i], upt[i], uppc[i]);
            up_q.push_back('{name: $sformatf("mispredict_case_%0d", i), mp: mp[i], rpc: rpc[i]});
            lk_q.push_back('{name: $sformatf("wrap_lookup_%0d", i), pt: 1'b0, ppc: 16'h0000});
            #1;
            ue = up_q.pop_front(); checks++;
            if (mispredict !== ue.mp || redirect_pc !== ue.rpc) begin
                errors++;
                $display("FAIL %s: mispredict=%0b redirect_pc=%h required %0b %h", ue.name, mispredict, redirect_pc, ue.mp, ue.rpc);
            end
            le = lk_q.pop_front(); checks++;
            if (pred_taken !== le.pt || pred_pc !== le.ppc) begin
                errors++;
                $display("FAIL %s: pred_taken=%0b pred_pc=%h required %0b %h", le.name, pred_taken, pred_pc, le.pt, le.ppc);
            end
            tick;
        end
    endtask

    task automatic test_async_reset;
        drive(16'h0010, 1'b1, 16'h0010, 1'b1, 16'h0040, 1'b0, 16'h0011);
        tick;
        drive(16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        lk_q.push_back('{name: "areset_before", pt: 1'b1, ppc: 16'h0040});
        lk_q.push_back('{name: "areset_immediate", pt: 1'b0, ppc: 16'h0011});
        lk_q.push_back('{name: "areset_update_dropped", pt: 1'b0, ppc: 16'h0011});
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                #2;
                rst = 1'b0;
                drive(16'h0010, 1'b1, 16'h0010, 1'b1, 16'h0090, 1'b0, 16'h0011);
            end
            if (i == 2) begin
                @(posedge clk);
                @(negedge clk);
                rst = 1'b1;
                drive(16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
            end
            #1;
            le = lk_q.pop_front(); checks++;
            if (pred_taken !== le.pt || pred_pc !== le.ppc) begin
                errors++;
                $display("FAIL %s: pred_taken=%0b pred_pc=%h required %0b %h", le.name, pred_taken, pred_pc, le.pt, le.ppc);
            end
        end
        tick;
    endtask

    task automatic test_stats;
        int exp_hit;
        int exp_miss;
        for (int i = 0; i < 5; i++) begin
            drive(16'h0400, 1'b1, 16'h0021 + PC_W'(i), 1'b1, 16'h0500, 1'b0, 16'h0000);
            tick;
        end
        drive(16'h0021, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        repeat (3) tick;
`ifdef BTB_STATS_EN
        exp_hit  = sat(3);
        exp_miss = sat(5);
`else
        exp_hit  = 0;
        exp_miss = 0;
`endif
        #1;
        checks++;
        if (hit_cnt !== STAT_W'(exp_hit) || miss_cnt !== STAT_W'(exp_miss)) begin
            errors++;
            $display("FAIL stats_count: hit_cnt=%0d miss_cnt=%0d required %0d %0d", hit_cnt, miss_cnt, exp_hit, exp_miss);
        end
        flush = 1'b1;
        drive(16'h0400, 1'b1, 16'h0022, 1'b1, 16'h0600, 1'b0, 16'h0000);
        tick;
        flush = 1'b0;
        drive(16'h0400, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        #1;
        checks++;
        if (hit_cnt !== '0 || miss_cnt !== '0) begin
            errors++;
            $display("FAIL stats_flush: hit_cnt=%0d miss_cnt=%0d required 0 0", hit_cnt, miss_cnt);
        end
        tick;
    endtask

    initial begin
        test_reset;
        @(negedge clk);
        test_allocate;
        test_saturation;
        test_aliasing;
        test_same_cycle;
        test_same_cycle_direct;
        test_mispredict;
        test_async_reset;
        test_stats;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
